neuron_step_scheduler: RTL and testbench

//  Sequences the shared potential_adder over NUM_NEURONS neurons.

---
 rtl/neuron_step_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_neuron_step_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_step_scheduler.sv
// Sequences the shared potential adder: a config pass loads the six model parameters,
// and a step pass runs every neuron through read -> adder -> membrane write-back.
module neuron_step_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   step_start,
    input  logic [1:0]             model_sel,
    output logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_data,
    output logic [IDX_W-1:0]       wacc_rd_addr,
    input  logic [31:0]            wacc_rd_data,
    output logic [IDX_W-1:0]       vmem_rd_addr,
    input  logic [31:0]            vmem_rd_data,
    output logic                   vmem_wr_en,
    output logic [IDX_W-1:0]       vmem_wr_addr,
    output logic [31:0]            vmem_wr_data,
    output logic                   adder_time_step,
    output logic                   adder_load,
    output logic [2:0]             adder_init_mode,
    output logic [1:0]             adder_model,
    output logic [31:0]            adder_input_weight,
    output logic [31:0]            adder_decayed_potential,
    input  logic                   adder_done,
    input  logic                   adder_spike,
    input  logic [31:0]            adder_final_potential,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   spike_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun_err
);

    localparam logic [2:0] MODE_DEFAULT = 3'd0;
    localparam logic [2:0] MODE_A       = 3'd1;
    localparam logic [2:0] MODE_B       = 3'd2;
    localparam logic [2:0] MODE_C       = 3'd3;
    localparam logic [2:0] MODE_D       = 3'd4;
    localparam logic [2:0] MODE_VT      = 3'd5;
    localparam logic [2:0] MODE_U       = 3'd6;
    localparam logic [2:0] LAST_PARAM   = 3'd5;
    localparam int         CNT_W        = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_RD,
        S_CFG_LAT,
        S_CFG_LD,
        S_RD,
        S_LAT,
        S_STEP,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [2:0]             param_reg;
    logic [CNT_W-1:0]       wait_cnt_reg;
    logic [1:0]             model_reg;
    logic [31:0]            weight_reg;
    logic [31:0]            decay_reg;
    logic [31:0]            result_reg;
    logic                   spike_bit_reg;
    logic [2:0]             init_mode_reg;
    logic                   timeout_reg;
    logic                   overrun_reg;
    logic [NUM_NEURONS-1:0] spike_vec_reg, spike_vec_next;

    logic step_entry;
    logic last_neuron;
    logic wait_expired;

    assign step_entry   = (state_reg == S_IDLE) && step_start && !cfg_start;
    assign last_neuron  = (idx_reg == IDX_W'(NUM_NEURONS - 1));
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    function automatic logic [2:0] param_code(input logic [2:0] k);
        case (k)
            3'd0:    param_code = MODE_A;
            3'd1:    param_code = MODE_B;
            3'd2:    param_code = MODE_C;
            3'd3:    param_code = MODE_D;
            3'd4:    param_code = MODE_VT;
            3'd5:    param_code = MODE_U;
            default: param_code = MODE_DEFAULT;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cfg_start)       state_next = S_CFG_RD;
                else if (step_start) state_next = S_RD;
            end
            S_CFG_RD:  state_next = S_CFG_LAT;
            S_CFG_LAT: state_next = S_CFG_LD;
            S_CFG_LD:  state_next = (param_reg == LAST_PARAM) ? S_IDLE : S_CFG_RD;
            S_RD:      state_next = S_LAT;
            S_LAT:     state_next = S_STEP;
            S_STEP:    state_next = S_WAIT;
            S_WAIT:    if (adder_done || wait_expired) state_next = S_WRITE;
            S_WRITE:   state_next = last_neuron ? S_DONE : S_RD;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg       <= '0;
            param_reg     <= '0;
            wait_cnt_reg  <= '0;
            model_reg     <= '0;
            weight_reg    <= '0;
            decay_reg     <= '0;
            result_reg    <= '0;
            spike_bit_reg <= 1'b0;
            init_mode_reg <= MODE_DEFAULT;
            timeout_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (state_reg != S_IDLE && (cfg_start || step_start))
                overrun_reg <= 1'b1;
            case (state_reg)
                S_IDLE: begin
                    if (cfg_start) begin
                        param_reg <= '0;
                        model_reg <= model_sel;
                    end else if (step_start) begin
                        idx_reg   <= '0;
                        model_reg <= model_sel;
                    end
                end
                S_CFG_LAT: begin
                    weight_reg    <= cfg_data;
                    init_mode_reg <= param_code(param_reg);
                end
                S_CFG_LD: begin
                    if (param_reg == LAST_PARAM) init_mode_reg <= MODE_DEFAULT;
                    else                         param_reg     <= param_reg + 3'd1;
                end
                S_RD: wait_cnt_reg <= '0;
                S_LAT: begin
                    weight_reg <= wacc_rd_data;
                    decay_reg  <= vmem_rd_data;
                end
                S_WAIT: begin
                    if (adder_done) begin
                        result_reg    <= adder_final_potential;
                        spike_bit_reg <= adder_spike;
                    end else if (wait_expired) begin
                        // Skipped neuron keeps its membrane value and does not spike
                        timeout_reg   <= 1'b1;
                        result_reg    <= decay_reg;
                        spike_bit_reg <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                S_WRITE: if (!last_neuron) idx_reg <= idx_reg + IDX_W'(1);
                S_DONE:  idx_reg <= '0;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_spike
        assign spike_vec_next[gi] = step_entry ? 1'b0 :
                                    (state_reg == S_WRITE && idx_reg == IDX_W'(gi)) ?
                                    spike_bit_reg : spike_vec_reg[gi];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) spike_vec_reg <= '0;
        else      spike_vec_reg <= spike_vec_next;
    end

    // During WRITE the read port already points at the next neuron, so it never aliases the write
    assign wacc_rd_addr = (state_reg == S_WRITE) ? idx_reg + IDX_W'(1) : idx_reg;
    assign vmem_rd_addr = wacc_rd_addr;

    assign cfg_addr                = param_reg;
    assign vmem_wr_en              = (state_reg == S_WRITE);
    assign vmem_wr_addr            = idx_reg;
    assign vmem_wr_data            = result_reg;
    assign adder_time_step         = (state_reg == S_STEP);
    assign adder_load              = (state_reg == S_CFG_LD);
    assign adder_init_mode         = init_mode_reg;
    assign adder_model             = model_reg;
    assign adder_input_weight      = weight_reg;
    assign adder_decayed_potential = decay_reg;
    assign spike_vec               = spike_vec_reg;
    assign spike_valid             = (state_reg == S_DONE);
    assign busy                    = (state_reg != S_IDLE);
    assign timeout_err             = timeout_reg;
    assign overrun_err             = overrun_reg;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: behavioural memories and LIF adder, queue scoreboard
// for adder loads and membrane writes, table-driven step passes plus corner sequences.
module tb_neuron_step_scheduler;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int TO    = 64;

    localparam logic [2:0] M_DEF = 3'd0;
    localparam logic [2:0] M_VT  = 3'd5;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start, step_start;
    logic [1:0]       model_sel;
    logic [2:0]       cfg_addr;
    logic [31:0]      cfg_data;
    logic [IDX_W-1:0] wacc_rd_addr, vmem_rd_addr, vmem_wr_addr;
    logic [31:0]      wacc_rd_data, vmem_rd_data, vmem_wr_data;
    logic             vmem_wr_en;
    logic             adder_time_step, adder_load;
    logic [2:0]       adder_init_mode;
    logic [1:0]       adder_model;
    logic [31:0]      adder_input_weight, adder_decayed_potential;
    logic             adder_done = 1'b0;
    logic             adder_spike = 1'b0;
    logic [31:0]      adder_final_potential = '0;
    logic [N-1:0]     spike_vec;
    logic             spike_valid, busy, timeout_err, overrun_err;

    always #5 clk = ~clk;

    neuron_step_scheduler #(.NUM_NEURONS(N), .IDX_W(IDX_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .step_start(step_start),
        .model_sel(model_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .wacc_rd_addr(wacc_rd_addr), .wacc_rd_data(wacc_rd_data),
        .vmem_rd_addr(vmem_rd_addr), .vmem_rd_data(vmem_rd_data),
        .vmem_wr_en(vmem_wr_en), .vmem_wr_addr(vmem_wr_addr), .vmem_wr_data(vmem_wr_data),
        .adder_time_step(adder_time_step), .adder_load(adder_load),
        .adder_init_mode(adder_init_mode), .adder_model(adder_model),
        .adder_input_weight(adder_input_weight),
        .adder_decayed_potential(adder_decayed_potential),
        .adder_done(adder_done), .adder_spike(adder_spike),
        .adder_final_potential(adder_final_potential),
        .spike_vec(spike_vec), .spike_valid(spike_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    // ---------------- memories and adder model ----------------
    logic [31:0] param_mem [8];
    logic [31:0] wacc_mem [N];
    logic [31:0] vmem_mem [N];
    logic [31:0] wacc_init [N];
    logic [31:0] vmem_init [N];
    logic        tb_load = 1'b0;
    int          stall_idx = -1;

    always @(posedge clk) begin
        cfg_data     <= param_mem[cfg_addr];
        wacc_rd_data <= wacc_mem[wacc_rd_addr];
        vmem_rd_data <= vmem_mem[vmem_rd_addr];
        if (tb_load) begin
            for (int i = 0; i < N; i++) begin
                wacc_mem[i] <= wacc_init[i];
                vmem_mem[i] <= vmem_init[i];
            end
        end else if (vmem_wr_en) begin
            vmem_mem[vmem_wr_addr] <= vmem_wr_data;
        end
    end

    logic [31:0] vt = 32'hFFFF_FFFF;
    always @(posedge clk) begin : adder_model_b
        logic [31:0] sum;
        adder_done <= 1'b0;
        if (adder_load && adder_init_mode == M_VT) vt <= adder_input_weight;
        if (adder_time_step && int'(wacc_rd_addr) != stall_idx) begin
            sum = adder_decayed_potential + adder_input_weight;
            adder_done <= 1'b1;
            if (sum >= vt) begin
                adder_spike           <= 1'b1;
                adder_final_potential <= sum - vt;
            end else begin
                adder_spike           <= 1'b0;
                adder_final_potential <= sum;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [IDX_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [2:0] mode; logic [31:0] data; } ld_t;
    typedef struct { logic [31:0] wacc; logic [31:0] vin; logic [31:0] wr; logic spk; } vec_t;

    wr_t  wr_q[$];
    ld_t  ld_q[$];
    int   load_cyc[$];
    wr_t  got_w;
    ld_t  got_l;
    vec_t cur [N];
    ld_t  params [6];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sv_count = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst && spike_valid) sv_count++;
        if (rst && vmem_wr_en) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL vmem_write: unexpected write addr=%0d data=%0d", vmem_wr_addr, vmem_wr_data);
            end else begin
                got_w = wr_q.pop_front();
                if (vmem_wr_addr !== got_w.addr || vmem_wr_data !== got_w.data) begin
                    errors++;
                    $display("FAIL vmem_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             vmem_wr_addr, vmem_wr_data, got_w.addr, got_w.data);
                end else
                    $display("ok vmem_write addr=%0d data=%0d", vmem_wr_addr, vmem_wr_data);
            end
        end
        if (rst && adder_load) begin
            checks++;
            load_cyc.push_back(cyc);
            if (ld_q.size() == 0) begin
                errors++;
                $display("FAIL adder_load: unexpected load mode=%0d data=%0d", adder_init_mode, adder_input_weight);
            end else begin
                got_l = ld_q.pop_front();
                if (adder_init_mode !== got_l.mode || adder_input_weight !== got_l.data) begin
                    errors++;
                    $display("FAIL adder_load: got mode=%0d data=%0d expected mode=%0d data=%0d",
                             adder_init_mode, adder_input_weight, got_l.mode, got_l.data);
                end else
                    $display("ok adder_load mode=%0d data=%0d", adder_init_mode, adder_input_weight);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else
            $display("ok %s: %0d", name, act);
    endtask

    task automatic pulse(input logic c, input logic s);
        @(negedge clk);
        cfg_start  = c;
        step_start = s;
        @(negedge clk);
        cfg_start  = 1'b0;
        step_start = 1'b0;
    endtask

    // Loads memories from cur[] and queues the first n_exp expected writes
    task automatic load_and_expect(input int n_exp, output logic [N-1:0] exp_spk);
        exp_spk = '0;
        for (int i = 0; i < N; i++) begin
            wacc_init[i] = cur[i].wacc;
            vmem_init[i] = cur[i].vin;
            exp_spk[i]   = cur[i].spk;
            if (i < n_exp) wr_q.push_back('{addr: IDX_W'(i), data: cur[i].wr});
        end
        @(negedge clk);
        tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int bound, output int n);
        n = start;
        while (!spike_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!spike_valid) n = -1;
    endtask

    task automatic count_busy(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic config_pass(input logic with_step, input string tag);
        int n;
        load_cyc.delete();
        for (int k = 0; k < 6; k++) ld_q.push_back(params[k]);
        pulse(1'b1, with_step);
        count_busy(100, n);
        check({tag, "_busy_cycles"}, n, 18);
        check({tag, "_load_count"}, load_cyc.size(), 6);
        for (int k = 1; k < load_cyc.size(); k++)
            check({tag, "_load_spacing"}, load_cyc[k] - load_cyc[k-1], 3);
        check({tag, "_loads_pending"}, ld_q.size(), 0);
        check({tag, "_init_mode_default"}, adder_init_mode, M_DEF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sv_before;
        logic [N-1:0] exp_spk;

        params[0] = '{mode: 3'd1, data: 32'd1};
        params[1] = '{mode: 3'd2, data: 32'd2};
        params[2] = '{mode: 3'd3, data: 32'd3};
        params[3] = '{mode: 3'd4, data: 32'd4};
        params[4] = '{mode: 3'd5, data: 32'd100};
        params[5] = '{mode: 3'd6, data: 32'd5};
        for (int k = 0; k < 8; k++) param_mem[k] = (k < 6) ? params[k].data : 32'hDEAD;

        rst = 1'b0; cfg_start = 1'b0; step_start = 1'b0; model_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_wr_en", vmem_wr_en, 0);
        check("reset_spike_valid", spike_valid, 0);
        check("reset_spike_vec", spike_vec, 0);
        check("reset_init_mode", adder_init_mode, M_DEF);
        check("reset_load", adder_load, 0);
        check("reset_time_step", adder_time_step, 0);
        check("reset_errs", {timeout_err, overrun_err}, 0);
        rst = 1'b1;

        // T1: config pass
        config_pass(1'b0, "t1");

        // T2: nominal step pass
        cur[0] = '{wacc: 10,  vin: 50, wr: 60,  spk: 1'b0};
        cur[1] = '{wacc: 60,  vin: 50, wr: 10,  spk: 1'b1};
        cur[2] = '{wacc: 0,   vin: 0,  wr: 0,   spk: 1'b0};
        cur[3] = '{wacc: 200, vin: 0,  wr: 100, spk: 1'b1};
        load_and_expect(N, exp_spk);
        pulse(1'b0, 1'b1);
        wait_valid(1, 300, n);
        check("t2_valid_cycle", n, 21);
        check("t2_spike_vec", spike_vec, exp_spk);
        @(negedge clk);
        check("t2_writes_pending", wr_q.size(), 0);
        check("t2_errs", {timeout_err, overrun_err}, 0);

        // T3: neuron 2 never answers
        stall_idx = 2;
        cur[0] = '{wacc: 5, vin: 60,  wr: 65, spk: 1'b0};
        cur[1] = '{wacc: 5, vin: 10,  wr: 15, spk: 1'b0};
        cur[2] = '{wacc: 5, vin: 70,  wr: 70, spk: 1'b0};
        cur[3] = '{wacc: 5, vin: 100, wr: 5,  spk: 1'b1};
        load_and_expect(N, exp_spk);
        pulse(1'b0, 1'b1);
        wait_valid(1, 300, n);
        check("t3_valid_cycle", n, 21 + TO - 1);
        check("t3_spike_vec", spike_vec, exp_spk);
        check("t3_timeout_err", timeout_err, 1);
        @(negedge clk);
        check("t3_vmem2_kept", vmem_mem[2], 70);
        check("t3_writes_pending", wr_q.size(), 0);
        stall_idx = -1;

        // T4: second step_start mid-pass
        cur[0] = '{wacc: 1, vin: 99, wr: 0, spk: 1'b1};
        cur[1] = '{wacc: 2, vin: 0,  wr: 2, spk: 1'b0};
        cur[2] = '{wacc: 3, vin: 0,  wr: 3, spk: 1'b0};
        cur[3] = '{wacc: 4, vin: 98, wr: 2, spk: 1'b1};
        load_and_expect(N, exp_spk);
        check("t4_overrun_before", overrun_err, 0);
        model_sel = 2'd2;
        pulse(1'b0, 1'b1);
        check("t4_model_latched", adder_model, 2);
        model_sel = 2'd1;
        repeat (5) @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        wait_valid(7, 300, n);
        check("t4_valid_cycle", n, 21);
        check("t4_spike_vec", spike_vec, exp_spk);
        check("t4_overrun_err", overrun_err, 1);
        check("t4_model_held", adder_model, 2);
        @(negedge clk);
        check("t4_busy_after", busy, 0);
        check("t4_writes_pending", wr_q.size(), 0);

        // T5: reset while waiting on neuron 1
        stall_idx = 1;
        cur[0] = '{wacc: 7,  vin: 3,  wr: 10, spk: 1'b0};
        cur[1] = '{wacc: 1,  vin: 1,  wr: 2,  spk: 1'b0};
        cur[2] = '{wacc: 50, vin: 60, wr: 10, spk: 1'b1};
        cur[3] = '{wacc: 0,  vin: 0,  wr: 0,  spk: 1'b0};
        load_and_expect(1, exp_spk);
        pulse(1'b0, 1'b1);
        n = 0;
        while (!(adder_time_step && wacc_rd_addr == 2'd1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_step1", (n < 60) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_wr_en", vmem_wr_en, 0);
        check("t5_rst_errs", {timeout_err, overrun_err}, 0);
        check("t5_rst_operands", adder_input_weight | adder_decayed_potential, 0);
        check("t5_rst_misc", {adder_model, adder_init_mode, adder_time_step, spike_valid}, 0);
        check("t5_rst_spike_vec", spike_vec, 0);
        check("t5_writes_pending", wr_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stall_idx = -1;
        load_and_expect(N, exp_spk);
        pulse(1'b0, 1'b1);
        wait_valid(1, 300, n);
        check("t5_clean_valid_cycle", n, 21);
        check("t5_clean_spike_vec", spike_vec, exp_spk);
        check("t5_clean_errs", {timeout_err, overrun_err}, 0);
        @(negedge clk);
        check("t5_clean_writes_pending", wr_q.size(), 0);

        // T6: both starts together -> config only
        sv_before = sv_count;
        config_pass(1'b1, "t6");
        repeat (3) @(negedge clk);
        check("t6_no_spike_valid", sv_count - sv_before, 0);
        check("t6_overrun_err", overrun_err, 0);
        check("t6_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
